led_pattern_gen: RTL



---
 rtl/led_pattern_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel active-low LED pattern generator: binary count, one-hot chase, PWM breathe, off.
// Define LED_GAMMA_EN to compare the breathe PWM against a registered square of the brightness.
module led_pattern_gen #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CLK_HZ     = 48000000,
    parameter int unsigned TICK_HZ    = 1000,
    parameter int unsigned STEP_TICKS = 250,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic                CLK_48,
    input  logic                RESET_N,
    input  logic [1:0]          mode,
    input  logic                mode_load,
    output logic [CHANNELS-1:0] led_n,
    output logic                tick,
    output logic                step
);

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [PW-1:0]       PRESC_MAX  = PW'(DIV - 1);
    localparam logic [SW-1:0]       STEP_MAX   = SW'(STEP_TICKS - 1);
    localparam logic [CHANNELS-1:0] CHASE_LAST = CHANNELS'(CHANNELS - 1);
    localparam logic [PWM_BITS-1:0] B_ONE      = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] B_NEAR_TOP = ~B_ONE;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
            $error("led_pattern_gen: CHANNELS must be within 1..16");
        end
    endgenerate

    mode_t               cur_mode_q, cur_mode_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic [CHANNELS-1:0] frame_q, frame_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic                ramp_down_q, ramp_down_d;
    logic [PWM_BITS-1:0] level;
    logic [CHANNELS-1:0] on;
    logic                mode_change;

    assign tick        = (presc_q == PRESC_MAX);
    assign step        = tick && (step_cnt_q == STEP_MAX);
    assign mode_change = mode_load && (mode_t'(mode) != cur_mode_q);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        pwm_d       = pwm_q + 1'b1;
        cur_mode_d  = cur_mode_q;
        step_cnt_d  = step_cnt_q;
        frame_d     = frame_q;
        bright_d    = bright_q;
        ramp_down_d = ramp_down_q;

        // A real mode change restarts the pattern and swallows any coincident advance.
        if (mode_change) begin
            cur_mode_d  = mode_t'(mode);
            step_cnt_d  = '0;
            frame_d     = '0;
            bright_d    = '0;
            ramp_down_d = 1'b0;
        end else if (tick) begin
            step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
            if (step) begin
                if (cur_mode_q == MODE_CHASE && frame_q >= CHASE_LAST)
                    frame_d = '0;
                else
                    frame_d = frame_q + 1'b1;
            end
            if (cur_mode_q == MODE_BREATHE) begin
                // Direction flips as the ramp arrives at an end, giving a 2*(2^PWM_BITS-1) tick period.
                if (!ramp_down_q) begin
                    bright_d = bright_q + 1'b1;
                    if (bright_q == B_NEAR_TOP)
                        ramp_down_d = 1'b1;
                end else begin
                    bright_d = bright_q - 1'b1;
                    if (bright_q == B_ONE)
                        ramp_down_d = 1'b0;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N) begin
            cur_mode_q  <= MODE_BINARY;
            presc_q     <= '0;
            step_cnt_q  <= '0;
            frame_q     <= '0;
            pwm_q       <= '0;
            bright_q    <= '0;
            ramp_down_q <= 1'b0;
        end else begin
            cur_mode_q  <= cur_mode_d;
            presc_q     <= presc_d;
            step_cnt_q  <= step_cnt_d;
            frame_q     <= frame_d;
            pwm_q       <= pwm_d;
            bright_q    <= bright_d;
            ramp_down_q <= ramp_down_d;
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] bright_wide;
    logic [2*PWM_BITS-1:0] bright_sq;
    logic [PWM_BITS-1:0]   gamma_q;

    assign bright_wide = {{PWM_BITS{1'b0}}, bright_q};
    assign bright_sq   = bright_wide * bright_wide;

    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N)
            gamma_q <= '0;
        else
            gamma_q <= PWM_BITS'(bright_sq >> PWM_BITS);
    end

    assign level = gamma_q;
`else
    assign level = bright_q;
`endif

    always_comb begin
        on = '0;
        case (cur_mode_q)
            MODE_BINARY: on = frame_q;
            MODE_CHASE: begin
                for (int i = 0; i < CHANNELS; i++)
                    on[i] = (frame_q == CHANNELS'(i));
            end
            MODE_BREATHE: on = {CHANNELS{pwm_q < level}};
            default:      on = '0;
        endcase
    end

    always_ff @(posedge CLK_48 or negedge RESET_N) begin
        if (!RESET_N)
            led_n <= '1;
        else
            led_n <= ~on;
    end

endmodule
